// File: rtl/axil_xbar_1xn.sv
// AXI4-Lite 1-master to NSLV-slave address decoder with one outstanding read and one write.
// Optional slave response timeout: define AXIL_XBAR_TIMEOUT_EN.
module axil_xbar_1xn #(
  parameter int NSLV        = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int SEL_LSB     = 28,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          m_awaddr,
  input  logic [2:0]             m_awprot,
  input  logic                   m_awvalid,
  output logic                   m_awready,
  input  logic [DW-1:0]          m_wdata,
  input  logic [DW/8-1:0]        m_wstrb,
  input  logic                   m_wvalid,
  output logic                   m_wready,
  output logic [1:0]             m_bresp,
  output logic                   m_bvalid,
  input  logic                   m_bready,
  input  logic [AW-1:0]          m_araddr,
  input  logic [2:0]             m_arprot,
  input  logic                   m_arvalid,
  output logic                   m_arready,
  output logic [DW-1:0]          m_rdata,
  output logic [1:0]             m_rresp,
  output logic                   m_rvalid,
  input  logic                   m_rready,
  output logic [NSLV*AW-1:0]     s_awaddr,
  output logic [NSLV*3-1:0]      s_awprot,
  output logic [NSLV-1:0]        s_awvalid,
  input  logic [NSLV-1:0]        s_awready,
  output logic [NSLV*DW-1:0]     s_wdata,
  output logic [NSLV*DW/8-1:0]   s_wstrb,
  output logic [NSLV-1:0]        s_wvalid,
  input  logic [NSLV-1:0]        s_wready,
  input  logic [NSLV*2-1:0]      s_bresp,
  input  logic [NSLV-1:0]        s_bvalid,
  output logic [NSLV-1:0]        s_bready,
  output logic [NSLV*AW-1:0]     s_araddr,
  output logic [NSLV*3-1:0]      s_arprot,
  output logic [NSLV-1:0]        s_arvalid,
  input  logic [NSLV-1:0]        s_arready,
  input  logic [NSLV*DW-1:0]     s_rdata,
  input  logic [NSLV*2-1:0]      s_rresp,
  input  logic [NSLV-1:0]        s_rvalid,
  output logic [NSLV-1:0]        s_rready
);

  localparam int SW = DW/8;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_WAIT = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_REQ  = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  if (NSLV < 1 || NSLV > 16 || SEL_LSB + 4 > AW || TIMEOUT_CYC < 1) begin : g_param_err
    $error("axil_xbar_1xn: illegal parameter set");
  end

  function automatic logic mapped(input logic [3:0] idx);
    return {1'b0, idx} < 5'(NSLV);
  endfunction

  logic [1:0]    w_state_q, w_state_d;
  logic          aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic          aw_sent_q, aw_sent_d, w_sent_q, w_sent_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [2:0]    awprot_q, awprot_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0]    bresp_q, bresp_d;

  logic [1:0]    r_state_q, r_state_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [2:0]    arprot_q, arprot_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

`ifdef AXIL_XBAR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
`endif

  // One-hot slave select, decoded from the latched addresses only
  logic [NSLV-1:0] woh, roh;
  for (genvar k = 0; k < NSLV; k++) begin : g_sel
    assign woh[k] = (awaddr_q[SEL_LSB+3:SEL_LSB] == 4'(k));
    assign roh[k] = (araddr_q[SEL_LSB+3:SEL_LSB] == 4'(k));
  end

  logic          awready_sel, wready_sel, bvalid_sel, arready_sel, rvalid_sel;
  logic [1:0]    bresp_sel, rresp_sel;
  logic [DW-1:0] rdata_sel;

  assign awready_sel = |(s_awready & woh);
  assign wready_sel  = |(s_wready  & woh);
  assign bvalid_sel  = |(s_bvalid  & woh);
  assign arready_sel = |(s_arready & roh);
  assign rvalid_sel  = |(s_rvalid  & roh);

  always_comb begin
    bresp_sel = '0;
    rresp_sel = '0;
    rdata_sel = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (woh[k]) bresp_sel = s_bresp[k*2 +: 2];
      if (roh[k]) begin
        rresp_sel = s_rresp[k*2 +: 2];
        rdata_sel = s_rdata[k*DW +: DW];
      end
    end
  end

  // Write path
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_sent_d = aw_sent_q;
    w_sent_d  = w_sent_q;
    awaddr_d  = awaddr_q;
    awprot_d  = awprot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (m_awvalid && m_awready) begin
          awaddr_d = m_awaddr;
          awprot_d = m_awprot;
          aw_got_d = 1'b1;
        end
        if (m_wvalid && m_wready) begin
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          w_got_d = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
          if (mapped(awaddr_d[SEL_LSB+3:SEL_LSB])) begin
            w_state_d = W_REQ;
          end else begin
            w_state_d = W_RESP;
            bresp_d   = 2'b11;
          end
        end
      end
      W_REQ: begin
        if (awready_sel && !aw_sent_q) aw_sent_d = 1'b1;
        if (wready_sel && !w_sent_q)   w_sent_d  = 1'b1;
        if (aw_sent_d && w_sent_d)     w_state_d = W_WAIT;
      end
      W_WAIT: begin
        if (bvalid_sel) begin
          bresp_d   = bresp_sel;
          w_state_d = W_RESP;
        end
      end
      default: begin
        if (m_bready) w_state_d = W_IDLE;
      end
    endcase
`ifdef AXIL_XBAR_TIMEOUT_EN
    wcnt_d = (w_state_q == W_REQ || w_state_q == W_WAIT) ? wcnt_q + CW'(1) : '0;
    if ((w_state_q == W_REQ || w_state_q == W_WAIT) && wcnt_q == CNT_LAST &&
        w_state_d != W_RESP) begin
      w_state_d = W_RESP;
      bresp_d   = 2'b10;
    end
`endif
  end

  // Read path
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arprot_d  = arprot_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (m_arvalid) begin
          araddr_d = m_araddr;
          arprot_d = m_arprot;
          if (mapped(m_araddr[SEL_LSB+3:SEL_LSB])) begin
            r_state_d = R_REQ;
          end else begin
            r_state_d = R_RESP;
            rresp_d   = 2'b11;
            rdata_d   = '0;
          end
        end
      end
      R_REQ: begin
        if (arready_sel) r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (rvalid_sel) begin
          rdata_d   = rdata_sel;
          rresp_d   = rresp_sel;
          r_state_d = R_RESP;
        end
      end
      default: begin
        if (m_rready) r_state_d = R_IDLE;
      end
    endcase
`ifdef AXIL_XBAR_TIMEOUT_EN
    rcnt_d = (r_state_q == R_REQ || r_state_q == R_WAIT) ? rcnt_q + CW'(1) : '0;
    if ((r_state_q == R_REQ || r_state_q == R_WAIT) && rcnt_q == CNT_LAST &&
        r_state_d != R_RESP) begin
      r_state_d = R_RESP;
      rresp_d   = 2'b10;
      rdata_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
      awaddr_q  <= '0;
      awprot_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arprot_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
      awaddr_q  <= awaddr_d;
      awprot_q  <= awprot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      arprot_q  <= arprot_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

`ifdef AXIL_XBAR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end
`endif

  assign m_awready = (w_state_q == W_IDLE) && !aw_got_q;
  assign m_wready  = (w_state_q == W_IDLE) && !w_got_q;
  assign m_bvalid  = (w_state_q == W_RESP);
  assign m_bresp   = bresp_q;
  assign m_arready = (r_state_q == R_IDLE);
  assign m_rvalid  = (r_state_q == R_RESP);
  assign m_rdata   = rdata_q;
  assign m_rresp   = rresp_q;

  // Payload is broadcast; only the selected slave sees a valid/ready
  assign s_awaddr  = {NSLV{awaddr_q}};
  assign s_awprot  = {NSLV{awprot_q}};
  assign s_wdata   = {NSLV{wdata_q}};
  assign s_wstrb   = {NSLV{wstrb_q}};
  assign s_araddr  = {NSLV{araddr_q}};
  assign s_arprot  = {NSLV{arprot_q}};
  assign s_awvalid = woh & {NSLV{(w_state_q == W_REQ) && !aw_sent_q}};
  assign s_wvalid  = woh & {NSLV{(w_state_q == W_REQ) && !w_sent_q}};
  assign s_bready  = woh & {NSLV{w_state_q == W_WAIT}};
  assign s_arvalid = roh & {NSLV{r_state_q == R_REQ}};
  assign s_rready  = roh & {NSLV{r_state_q == R_WAIT}};

endmodule

// File: tb/tb_axil_xbar_1xn.sv
// Bench for axil_xbar_1xn: behavioural slave responders plus directed and randomized master traffic.
module tb_axil_xbar_1xn;
  localparam int NSLV = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW/8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic [1:0]    m_bresp, m_rresp;

  logic [NSLV*AW-1:0]   s_awaddr, s_araddr;
  logic [NSLV*3-1:0]    s_awprot, s_arprot;
  logic [NSLV*DW-1:0]   s_wdata, s_rdata;
  logic [NSLV*SW-1:0]   s_wstrb;
  logic [NSLV*2-1:0]    s_bresp, s_rresp;
  logic [NSLV-1:0]      s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [NSLV-1:0]      s_awready = '1, s_wready = '1, s_arready = '1;
  logic [NSLV-1:0]      s_bvalid, s_rvalid;

  axil_xbar_1xn #(.NSLV(NSLV), .AW(AW), .DW(DW), .SEL_LSB(28), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  int total = 0;
  int bad   = 0;

  // Slave configuration, set by the tests
  logic [31:0] rd_data[NSLV];
  logic [1:0]  r_resp_cfg[NSLV], b_resp_cfg[NSLV];
  int          r_wait[NSLV], b_wait[NSLV];
  bit          b_never[NSLV];
  bit          rnd_rdy = 1'b0;

  // Slave-side observations
  int          aw_cnt[NSLV] = '{default: 0};
  int          w_cnt[NSLV]  = '{default: 0};
  int          ar_cnt[NSLV] = '{default: 0};
  logic [31:0] last_awaddr[NSLV], last_wdata[NSLV], last_araddr[NSLV];
  logic [3:0]  last_wstrb[NSLV];
  int          multi_sel = 0;

  logic [NSLV-1:0] got_aw, got_w, bpend, rpend, bv, rv;
  int              btimer[NSLV], rtimer[NSLV];
  logic [NSLV-1:0] aw_hs, w_hs, ar_hs;
  assign aw_hs    = s_awvalid & s_awready;
  assign w_hs     = s_wvalid & s_wready;
  assign ar_hs    = s_arvalid & s_arready;
  assign s_bvalid = bv;
  assign s_rvalid = rv;

  always_comb begin
    s_bresp = '0;
    s_rresp = '0;
    s_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      s_bresp[k*2 +: 2]  = b_resp_cfg[k];
      s_rresp[k*2 +: 2]  = r_resp_cfg[k];
      s_rdata[k*DW +: DW] = rd_data[k];
    end
  end

  always @(posedge clk) begin
    s_awready <= rnd_rdy ? NSLV'($urandom) : '1;
    s_wready  <= rnd_rdy ? NSLV'($urandom) : '1;
    s_arready <= rnd_rdy ? NSLV'($urandom) : '1;
  end

  always @(posedge clk) begin
    for (int k = 0; k < NSLV; k++) begin
      if (aw_hs[k]) begin
        aw_cnt[k]      <= aw_cnt[k] + 1;
        last_awaddr[k] <= s_awaddr[k*AW +: AW];
      end
      if (w_hs[k]) begin
        w_cnt[k]      <= w_cnt[k] + 1;
        last_wdata[k] <= s_wdata[k*DW +: DW];
        last_wstrb[k] <= s_wstrb[k*SW +: SW];
      end
      if (ar_hs[k]) begin
        ar_cnt[k]      <= ar_cnt[k] + 1;
        last_araddr[k] <= s_araddr[k*AW +: AW];
      end
      if (rst) begin
        got_aw[k] <= 1'b0; got_w[k] <= 1'b0; bpend[k] <= 1'b0; bv[k] <= 1'b0;
        rpend[k]  <= 1'b0; rv[k] <= 1'b0;
      end else begin
        if ((got_aw[k] || aw_hs[k]) && (got_w[k] || w_hs[k])) begin
          got_aw[k] <= 1'b0;
          got_w[k]  <= 1'b0;
          if (!b_never[k]) begin
            if (b_wait[k] == 0) bv[k] <= 1'b1;
            else begin bpend[k] <= 1'b1; btimer[k] <= b_wait[k]; end
          end
        end else begin
          got_aw[k] <= got_aw[k] || aw_hs[k];
          got_w[k]  <= got_w[k] || w_hs[k];
        end
        if (bpend[k]) begin
          if (btimer[k] <= 1) begin bv[k] <= 1'b1; bpend[k] <= 1'b0; end
          else btimer[k] <= btimer[k] - 1;
        end
        if (bv[k] && s_bready[k]) bv[k] <= 1'b0;
        if (ar_hs[k]) begin
          if (r_wait[k] == 0) rv[k] <= 1'b1;
          else begin rpend[k] <= 1'b1; rtimer[k] <= r_wait[k]; end
        end
        if (rpend[k]) begin
          if (rtimer[k] <= 1) begin rv[k] <= 1'b1; rpend[k] <= 1'b0; end
          else rtimer[k] <= rtimer[k] - 1;
        end
        if (rv[k] && s_rready[k]) rv[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if ($countones(s_awvalid) > 1 || $countones(s_wvalid) > 1 || $countones(s_bready) > 1 ||
        $countones(s_arvalid) > 1 || $countones(s_rready) > 1)
      multi_sel <= multi_sel + 1;
  end

  // ---------------- master tasks ----------------
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                    output int lat);
    int n = 0;
    d = 'x; r = 'x; lat = -1;
    m_araddr = a; m_arprot = 3'($urandom); m_arvalid = 1'b1;
    @(negedge clk);
    while (!m_arready && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    m_arvalid = 1'b0;
    if (n < 100) begin
      m_rready = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!m_rvalid && lat < 300);
      if (m_rvalid) begin d = m_rdata; r = m_rresp; end
      else lat = -1;
      @(posedge clk); #1;
      m_rready = 1'b0;
    end
  endtask

  task automatic send_aw(input int dly, input logic [31:0] a);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    m_awaddr = a; m_awprot = 3'($urandom); m_awvalid = 1'b1;
    @(negedge clk);
    while (!m_awready && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    m_awvalid = 1'b0;
  endtask

  task automatic send_w(input int dly, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    m_wdata = d; m_wstrb = s; m_wvalid = 1'b1;
    @(negedge clk);
    while (!m_wready && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    m_wvalid = 1'b0;
  endtask

  // w_lead > 0: W goes first by that many cycles; < 0: AW goes first
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_lead, output logic [1:0] r, output int lat);
    r = 'x;
    fork
      send_aw(w_lead > 0 ? w_lead : 0, a);
      send_w(w_lead < 0 ? -w_lead : 0, d, s);
    join
    m_bready = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!m_bvalid && lat < 300);
    if (m_bvalid) r = m_bresp;
    else lat = -1;
    @(posedge clk); #1;
    m_bready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({m_awready, m_wready, m_arready} !== 3'b111) begin
      bad++; $display("FAIL reset_readies got=%b exp=111", {m_awready, m_wready, m_arready});
    end
    total++;
    if ({m_bvalid, m_rvalid, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} !== '0) begin
      bad++; $display("FAIL reset_valids got=%b exp=0",
                      {m_bvalid, m_rvalid, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready});
    end
    total++;
    if ({m_bresp, m_rresp, m_rdata} !== '0) begin
      bad++; $display("FAIL reset_resp got=%h exp=0", {m_bresp, m_rresp, m_rdata});
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] d; logic [1:0] r; int lat; int b[NSLV];
    rd_data[1] = 32'hDEADBEEF; r_resp_cfg[1] = 2'b00; r_wait[1] = 0;
    for (int k = 0; k < NSLV; k++) b[k] = ar_cnt[k];
    @(posedge clk); #1;
    rd(32'h1000_0004, d, r, lat);
    total++;
    if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", d); end
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL read_resp got=%b exp=00", r); end
    total++;
    if (lat != 3) begin bad++; $display("FAIL read_latency got=%0d exp=3", lat); end
    total++;
    if (last_araddr[1] !== 32'h1000_0004) begin
      bad++; $display("FAIL read_slave_addr got=%h exp=10000004", last_araddr[1]);
    end
    for (int k = 0; k < NSLV; k++) begin
      total++;
      if (ar_cnt[k] - b[k] != ((k == 1) ? 1 : 0)) begin
        bad++; $display("FAIL read_ar_beats slave=%0d got=%0d exp=%0d", k, ar_cnt[k] - b[k],
                        (k == 1) ? 1 : 0);
      end
    end
  endtask

  task automatic test_write_basic();
    logic [1:0] r; int lat; int ba[NSLV]; int bw[NSLV];
    b_resp_cfg[0] = 2'b00; b_wait[0] = 0;
    for (int k = 0; k < NSLV; k++) begin ba[k] = aw_cnt[k]; bw[k] = w_cnt[k]; end
    wr(32'h0000_0010, 32'h1234_5678, 4'b0011, 2, r, lat);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL write_resp got=%b exp=00", r); end
    total++;
    if ({last_awaddr[0], last_wdata[0], last_wstrb[0]} !== {32'h10, 32'h1234_5678, 4'b0011}) begin
      bad++; $display("FAIL write_slave_beat got=%h/%h/%b exp=00000010/12345678/0011",
                      last_awaddr[0], last_wdata[0], last_wstrb[0]);
    end
    for (int k = 0; k < NSLV; k++) begin
      total++;
      if (aw_cnt[k] - ba[k] != ((k == 0) ? 1 : 0) || w_cnt[k] - bw[k] != ((k == 0) ? 1 : 0)) begin
        bad++; $display("FAIL write_beats slave=%0d got aw=%0d w=%0d exp=%0d", k,
                        aw_cnt[k] - ba[k], w_cnt[k] - bw[k], (k == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_decerr();
    logic [31:0] d; logic [1:0] r; int lat; int sum0; int sum1;
    logic [31:0] addrs[3];
    addrs[0] = 32'h5000_0000; addrs[1] = 32'h4000_0008; addrs[2] = 32'hF000_00FC;
    sum0 = 0;
    for (int k = 0; k < NSLV; k++) sum0 += aw_cnt[k] + w_cnt[k] + ar_cnt[k];
    for (int i = 0; i < 3; i++) begin
      rd(addrs[i], d, r, lat);
      total++;
      if ({r, d} !== {2'b11, 32'h0} || lat != 1) begin
        bad++; $display("FAIL decerr_read addr=%h got resp=%b data=%h lat=%0d exp 11/0/1",
                        addrs[i], r, d, lat);
      end
      wr(addrs[i], $urandom, 4'hF, i - 1, r, lat);
      total++;
      if (r !== 2'b11 || lat != 1) begin
        bad++; $display("FAIL decerr_write addr=%h got resp=%b lat=%0d exp 11/1", addrs[i], r, lat);
      end
    end
    sum1 = 0;
    for (int k = 0; k < NSLV; k++) sum1 += aw_cnt[k] + w_cnt[k] + ar_cnt[k];
    total++;
    if (sum1 != sum0) begin bad++; $display("FAIL decerr_slave_beats got=%0d exp=0", sum1 - sum0); end
  endtask

  task automatic test_concurrent();
    logic [31:0] d, ed; logic [1:0] rr, br; int rl, wl; time trd, twr;
    int b_ar2, b_aw2, b_ar3, b_aw3;
    ed = $urandom; rd_data[2] = ed; r_resp_cfg[2] = 2'b00; r_wait[2] = 10;
    b_resp_cfg[3] = 2'b01; b_wait[3] = 0;
    b_ar2 = ar_cnt[2]; b_aw2 = aw_cnt[2]; b_ar3 = ar_cnt[3]; b_aw3 = aw_cnt[3];
    fork
      begin rd(32'h2000_0100, d, rr, rl); trd = $time; end
      begin wr(32'h3000_0008, 32'hCAFE_F00D, 4'hF, 0, br, wl); twr = $time; end
    join
    total++;
    if (!(twr < trd)) begin bad++; $display("FAIL conc_order got wr=%0t rd=%0t exp wr first", twr, trd); end
    total++;
    if ({d, rr} !== {ed, 2'b00}) begin bad++; $display("FAIL conc_read got=%h/%b exp=%h/00", d, rr, ed); end
    total++;
    if (br !== 2'b01) begin bad++; $display("FAIL conc_write got=%b exp=01", br); end
    total++;
    if (ar_cnt[2] - b_ar2 != 1 || aw_cnt[2] - b_aw2 != 0 || ar_cnt[3] - b_ar3 != 0 ||
        aw_cnt[3] - b_aw3 != 1 || last_wdata[3] !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL conc_beats got ar2=%0d aw2=%0d ar3=%0d aw3=%0d exp 1 0 0 1",
                      ar_cnt[2] - b_ar2, aw_cnt[2] - b_aw2, ar_cnt[3] - b_ar3, aw_cnt[3] - b_aw3);
    end
    r_wait[2] = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat; int n = 0;
    r_wait[2] = 50;
    m_araddr = 32'h2000_0040; m_arvalid = 1'b1;
    @(posedge clk); #1;
    m_arvalid = 1'b0;
    @(negedge clk);
    while (!s_rready[2] && n < 20) begin n++; @(negedge clk); end
    total++;
    if (!s_rready[2]) begin bad++; $display("FAIL rstmid_reach_wait got s_rready=%b exp=1", s_rready[2]); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({s_rready, s_arvalid, m_rvalid, m_arready} !== {{(2*NSLV){1'b0}}, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rstmid_state got rready=%b arvalid=%b rvalid=%b arready=%b exp 0 0 0 1",
                      s_rready, s_arvalid, m_rvalid, m_arready);
    end
    @(posedge clk); #1 rst = 1'b0;
    r_wait[2] = 1; rd_data[2] = 32'h0BAD_CAFE; r_resp_cfg[2] = 2'b00;
    rd(32'h2000_0044, d, r, lat);
    total++;
    if ({d, r} !== {32'h0BAD_CAFE, 2'b00} || lat != 4) begin
      bad++; $display("FAIL rstmid_next_read got=%h/%b lat=%0d exp=0badcafe/00 lat=4", d, r, lat);
    end
    r_wait[2] = 0;
  endtask

`ifdef AXIL_XBAR_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] r; int lat;
    b_never[1] = 1'b1;
    wr(32'h1000_0020, 32'h1111_2222, 4'hF, 0, r, lat);
    total++;
    if (r !== 2'b10 || lat != 9) begin
      bad++; $display("FAIL timeout_write got=%b lat=%0d exp=10 lat=9", r, lat);
    end
    b_never[1] = 1'b0; b_resp_cfg[1] = 2'b00; b_wait[1] = 1;
    wr(32'h1000_0024, 32'h3333_4444, 4'hF, 0, r, lat);
    total++;
    if (r !== 2'b00 || last_wdata[1] !== 32'h3333_4444) begin
      bad++; $display("FAIL timeout_recover got=%b/%h exp=00/33334444", r, last_wdata[1]);
    end
  endtask
`endif

  task automatic test_random();
    int ex_aw[NSLV]; int ex_w[NSLV]; int ex_ar[NSLV];
    rnd_rdy = 1'b1;
    for (int k = 0; k < NSLV; k++) begin ex_aw[k] = aw_cnt[k]; ex_w[k] = w_cnt[k]; ex_ar[k] = ar_cnt[k]; end
    for (int it = 0; it < 40; it++) begin
      int op, ri, wi, rl, wl, lead;
      logic [31:0] ra, wa, wd, d, ed; logic [3:0] ws; logic [1:0] rr, br, err, ebr;
      op = $urandom_range(0, 2);
      ri = $urandom_range(0, 5); wi = $urandom_range(0, 5);
      ra = {4'(ri), 26'($urandom), 2'b00};
      wa = {4'(wi), 26'($urandom), 2'b00};
      wd = $urandom; ws = 4'($urandom); lead = $urandom_range(0, 6) - 3;
      if (ri < NSLV) begin
        rd_data[ri] = $urandom; r_resp_cfg[ri] = 2'($urandom_range(0, 2)); r_wait[ri] = $urandom_range(0, 4);
      end
      if (wi < NSLV) begin
        b_resp_cfg[wi] = 2'($urandom_range(0, 2)); b_wait[wi] = $urandom_range(0, 4);
      end
      ed  = (ri < NSLV) ? rd_data[ri] : 32'h0;
      err = (ri < NSLV) ? r_resp_cfg[ri] : 2'b11;
      ebr = (wi < NSLV) ? b_resp_cfg[wi] : 2'b11;
      if (op == 0) rd(ra, d, rr, rl);
      else if (op == 1) wr(wa, wd, ws, lead, br, wl);
      else fork rd(ra, d, rr, rl); wr(wa, wd, ws, lead, br, wl); join
      if (op != 1) begin
        if (ri < NSLV) ex_ar[ri]++;
        total++;
        if ({d, rr} !== {ed, err}) begin
          bad++; $display("FAIL rand_read it=%0d addr=%h got=%h/%b exp=%h/%b", it, ra, d, rr, ed, err);
        end
      end
      if (op != 0) begin
        total++;
        if (br !== ebr) begin bad++; $display("FAIL rand_write it=%0d addr=%h got=%b exp=%b", it, wa, br, ebr); end
        if (wi < NSLV) begin
          ex_aw[wi]++; ex_w[wi]++;
          total++;
          if ({last_awaddr[wi], last_wdata[wi], last_wstrb[wi]} !== {wa, wd, ws}) begin
            bad++; $display("FAIL rand_write_beat it=%0d got=%h/%h/%b exp=%h/%h/%b", it,
                            last_awaddr[wi], last_wdata[wi], last_wstrb[wi], wa, wd, ws);
          end
        end
      end
    end
    for (int k = 0; k < NSLV; k++) begin
      total++;
      if (aw_cnt[k] != ex_aw[k] || w_cnt[k] != ex_w[k] || ar_cnt[k] != ex_ar[k]) begin
        bad++; $display("FAIL rand_beats slave=%0d got aw=%0d w=%0d ar=%0d exp %0d %0d %0d", k,
                        aw_cnt[k], w_cnt[k], ar_cnt[k], ex_aw[k], ex_w[k], ex_ar[k]);
      end
    end
    total++;
    if (multi_sel != 0) begin bad++; $display("FAIL one_hot_select got=%0d cycles exp=0", multi_sel); end
    rnd_rdy = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NSLV; k++) begin
      rd_data[k] = '0; r_resp_cfg[k] = '0; b_resp_cfg[k] = '0;
      r_wait[k] = 0; b_wait[k] = 0; b_never[k] = 1'b0;
    end
    m_awaddr = '0; m_awprot = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
    m_bready = 1'b0; m_araddr = '0; m_arprot = '0; m_arvalid = 1'b0; m_rready = 1'b0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_decerr();
    test_concurrent();
    test_reset_mid();
`ifdef AXIL_XBAR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_xbar_1xn.md
Name: axil_xbar_1xn

Overview:
- Parametrised AXI4-Lite 1-master to N-slave address decoder.
- Sits between `core` and the SoC memories and peripherals, replacing the fixed point-to-point core-to-IRAM hookup.
- Independent read and write paths, each with one outstanding transaction.
- Unmapped addresses get an internal DECERR response, so the core never hangs on a bad address.

Parameters:
- NSLV, 4, number of slave ports (1..16).
- AW, 32, address width.
- DW, 32, data width (wstrb width DW/8).
- SEL_LSB, 28, lowest address bit of the slave-select field; field is addr[SEL_LSB+3:SEL_LSB].
- TIMEOUT_CYC, 255, slave response timeout in cycles; used only with AXIL_XBAR_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- m_awaddr/m_awprot/m_awvalid/m_awready  in/in/in/out  AW/3/1/1  master write address
- m_wdata/m_wstrb/m_wvalid/m_wready  in/in/in/out  DW/DW/8/1/1  master write data
- m_bresp/m_bvalid/m_bready  out/out/in  2/1/1  master write response
- m_araddr/m_arprot/m_arvalid/m_arready  in/in/in/out  AW/3/1/1  master read address
- m_rdata/m_rresp/m_rvalid/m_rready  out/out/out/in  DW/2/1/1  master read data
- s_awaddr/s_awprot  out  NSLV*AW / NSLV*3  slave write address, flattened, slave k at slice k
- s_awvalid/s_awready  out/in  NSLV  per-slave handshake
- s_wdata/s_wstrb  out  NSLV*DW / NSLV*DW/8  per-slave write data and strobes
- s_wvalid/s_wready  out/in  NSLV  per-slave handshake
- s_bresp  in  NSLV*2  per-slave write response
- s_bvalid/s_bready  in/out  NSLV  per-slave handshake
- s_araddr/s_arprot  out  NSLV*AW / NSLV*3  per-slave read address
- s_arvalid/s_arready  out/in  NSLV  per-slave handshake
- s_rdata/s_rresp  in  NSLV*DW / NSLV*2  per-slave read data and response
- s_rvalid/s_rready  in/out  NSLV  per-slave handshake

Behaviour:
- Reset state: all FSMs IDLE. All valids and s_*ready are 0. m_bresp, m_rresp and m_rdata are 0. m_awready, m_wready and m_arready are 1 in the first cycle after reset.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any ready or valid output.
- Slave index idx = addr[SEL_LSB+3:SEL_LSB]. idx >= NSLV is unmapped.
- Address, prot, data and strobes are broadcast to all slave slices. Only s_*valid[idx] and s_*ready[idx] are asserted; all other bits stay 0.

Write FSM (W_IDLE, W_REQ, W_WAIT, W_RESP):
- W_IDLE:
  - AW and W are accepted independently; m_awready and m_wready each drop once their beat is latched.
  - When both are latched: go to W_REQ if idx is mapped, otherwise go to W_RESP with bresp=2'b11.
  - AW and W arriving in the same cycle are both accepted.
- W_REQ:
  - Hold s_awvalid[idx] and s_wvalid[idx]; each deasserts after its own handshake.
  - After both handshakes, go to W_WAIT.
- W_WAIT: s_bready[idx]=1. On s_bvalid[idx], latch s_bresp and go to W_RESP.
- W_RESP:
  - m_bvalid=1 until m_bready is seen.
  - Then go to W_IDLE with m_awready=1 and m_wready=1 in the next cycle.

Read FSM (R_IDLE, R_REQ, R_WAIT, R_RESP):
- R_IDLE: m_arready=1. On handshake, latch the address; go to R_REQ if mapped, otherwise to R_RESP with rresp=2'b11 and rdata=0.
- R_REQ: s_arvalid[idx]=1 until s_arready[idx], then R_WAIT.
- R_WAIT: s_rready[idx]=1. On s_rvalid[idx], latch rdata and rresp, then R_RESP.
- R_RESP: m_rvalid=1 with stable data until m_rready, then R_IDLE.

Latency and concurrency:
- With a zero-wait slave (arready=1, rvalid one cycle after the AR handshake), m_rvalid rises 3 cycles after the m_ar handshake cycle.
- A DECERR response appears 1 cycle after the handshake.
- The read and write paths run concurrently, including to the same slave.
- A master valid held during RESP is not accepted until the FSM returns to IDLE.

Reset mid-transaction:
- The FSM returns to IDLE and all valids drop in the next cycle.
- The in-flight transaction is abandoned; slaves are reset together with this block.

Optional Feature:
- AXIL_XBAR_TIMEOUT_EN defined:
  - A per-path counter runs in W_REQ/W_WAIT and in R_REQ/R_WAIT.
  - After TIMEOUT_CYC cycles without completion, the path drops its slave valids and readies and goes to RESP with resp=2'b10 (SLVERR) and rdata=0.
  - The counter clears on every transition into REQ.
- AXIL_XBAR_TIMEOUT_EN undefined: no counter is built, and a path waits forever on its slave.

Test Plan:
- Read 0x1000_0004 from slave 1, which returns 0xDEADBEEF with zero wait -> only s_arvalid[1] pulses; m_rdata=0xDEADBEEF, m_rresp=0, m_rvalid 3 cycles after the handshake.
- Write 0x0000_0010 with data 0x12345678 and strb 4'b0011; W presented 2 cycles before AW -> slave 0 sees exactly one AW beat and one W beat with the same data and strb; m_bresp=0.
- Read and write 0x5000_0000 with NSLV=4 -> no s_*valid asserted; rresp=2'b11 with rdata=0 one cycle after the handshake; bresp=2'b11.
- Concurrent read of slave 2 and write to slave 3, with slave 2 stalling rvalid for 10 cycles -> the write completes first and the read completes afterwards; no cross-channel interference.
- Assert rst while in R_WAIT -> next cycle s_rready=0, m_rvalid=0, m_arready=1; a following read completes normally.
- With AXIL_XBAR_TIMEOUT_EN and TIMEOUT_CYC=8, a slave that never asserts bvalid -> m_bresp=2'b10 about 9 cycles after entering W_REQ; the next transaction completes normally.
